wb_arbiter: RTL



---
 rtl/wb_arbiter.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : wb_arbiter
// Purpose  : Three-source writeback arbiter with per-source FIFOs and a
//            round-robin grant onto the single register-file write port.
// Revision : 1.0  initial release
// ============================================================================
module wb_arbiter #(
    parameter int DEPTH  = 2,
    parameter int ADDR_W = 6,
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              alu_valid,
    output logic              alu_ready,
    input  logic [ADDR_W-1:0] alu_addr,
    input  logic [DATA_W-1:0] alu_data,
    input  logic              fpu_valid,
    output logic              fpu_ready,
    input  logic [ADDR_W-1:0] fpu_addr,
    input  logic [DATA_W-1:0] fpu_data,
    input  logic              mem_valid,
    output logic              mem_ready,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_data,
    output logic              write_enable,
    output logic [ADDR_W-1:0] write_addr,
    output logic [DATA_W-1:0] write_data,
    output logic              idle
);

    localparam int c_NSRC  = 3;
    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0] c_FULL = c_CNT_W'(DEPTH);

    logic               w_in_valid [c_NSRC];
    logic [ADDR_W-1:0]  w_in_addr  [c_NSRC];
    logic [DATA_W-1:0]  w_in_data  [c_NSRC];
    logic               w_push     [c_NSRC];
    logic               w_pop      [c_NSRC];

    logic [ADDR_W-1:0]  fifo_addr_q [c_NSRC][DEPTH];
    logic [DATA_W-1:0]  fifo_data_q [c_NSRC][DEPTH];
    logic [c_PTR_W-1:0] wr_ptr_q [c_NSRC];
    logic [c_PTR_W-1:0] wr_ptr_d [c_NSRC];
    logic [c_PTR_W-1:0] rd_ptr_q [c_NSRC];
    logic [c_PTR_W-1:0] rd_ptr_d [c_NSRC];
    logic [c_CNT_W-1:0] cnt_q    [c_NSRC];
    logic [c_CNT_W-1:0] cnt_d    [c_NSRC];

    logic [1:0]         rr_ptr_q, rr_ptr_d;
    logic               write_enable_q, write_enable_d;
    logic [ADDR_W-1:0]  write_addr_q, write_addr_d;
    logic [DATA_W-1:0]  write_data_q, write_data_d;

    logic               w_grant;
    logic [1:0]         w_grant_idx;
    logic [ADDR_W-1:0]  w_head_addr;
    logic [DATA_W-1:0]  w_head_data;

    assign w_in_valid[0] = alu_valid;
    assign w_in_valid[1] = fpu_valid;
    assign w_in_valid[2] = mem_valid;
    assign w_in_addr[0]  = alu_addr;
    assign w_in_addr[1]  = fpu_addr;
    assign w_in_addr[2]  = mem_addr;
    assign w_in_data[0]  = alu_data;
    assign w_in_data[1]  = fpu_data;
    assign w_in_data[2]  = mem_data;

    // Ready reflects only the stored count, so a pop never frees a slot early.
    assign alu_ready = (cnt_q[0] < c_FULL);
    assign fpu_ready = (cnt_q[1] < c_FULL);
    assign mem_ready = (cnt_q[2] < c_FULL);

    function automatic logic [1:0] f_src(input logic [1:0] base, input int k);
        int s;
        s = int'(base) + k;
        if (s >= c_NSRC) s = s - c_NSRC;
        return 2'(s);
    endfunction

    // Scan from lowest to highest priority so the highest-priority hit wins last.
    always_comb begin
        w_grant     = 1'b0;
        w_grant_idx = 2'd0;
        for (int k = c_NSRC - 1; k >= 0; k--) begin
            if (cnt_q[f_src(rr_ptr_q, k)] != '0) begin
                w_grant     = 1'b1;
                w_grant_idx = f_src(rr_ptr_q, k);
            end
        end
        w_head_addr = fifo_addr_q[w_grant_idx][rd_ptr_q[w_grant_idx]];
        w_head_data = fifo_data_q[w_grant_idx][rd_ptr_q[w_grant_idx]];
    end

    always_comb begin
        for (int i = 0; i < c_NSRC; i++) begin
            w_push[i]   = w_in_valid[i] && (cnt_q[i] < c_FULL);
            w_pop[i]    = w_grant && (w_grant_idx == 2'(i));
            wr_ptr_d[i] = w_push[i] ? wr_ptr_q[i] + c_PTR_W'(1) : wr_ptr_q[i];
            rd_ptr_d[i] = w_pop[i]  ? rd_ptr_q[i] + c_PTR_W'(1) : rd_ptr_q[i];
            cnt_d[i]    = cnt_q[i];
            if (w_push[i] && !w_pop[i]) cnt_d[i] = cnt_q[i] + c_CNT_W'(1);
            if (!w_push[i] && w_pop[i]) cnt_d[i] = cnt_q[i] - c_CNT_W'(1);
        end
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (w_grant) rr_ptr_d = (w_grant_idx == 2'd2) ? 2'd0 : w_grant_idx + 2'd1;
        // Writes to x0 still consume a grant but leave the port quiet.
        write_enable_d = w_grant && (w_head_addr != '0);
        write_addr_d   = write_enable_d ? w_head_addr : write_addr_q;
        write_data_d   = write_enable_d ? w_head_data : write_data_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < c_NSRC; i++) begin
                wr_ptr_q[i] <= '0;
                rd_ptr_q[i] <= '0;
                cnt_q[i]    <= '0;
            end
            rr_ptr_q       <= 2'd0;
            write_enable_q <= 1'b0;
            write_addr_q   <= '0;
            write_data_q   <= '0;
        end else begin
            for (int i = 0; i < c_NSRC; i++) begin
                wr_ptr_q[i] <= wr_ptr_d[i];
                rd_ptr_q[i] <= rd_ptr_d[i];
                cnt_q[i]    <= cnt_d[i];
            end
            rr_ptr_q       <= rr_ptr_d;
            write_enable_q <= write_enable_d;
            write_addr_q   <= write_addr_d;
            write_data_q   <= write_data_d;
        end
    end

    // Storage needs no reset: entries are only read while the count is nonzero.
    always_ff @(posedge clk) begin
        for (int i = 0; i < c_NSRC; i++) begin
            if (w_push[i]) begin
                fifo_addr_q[i][wr_ptr_q[i]] <= w_in_addr[i];
                fifo_data_q[i][wr_ptr_q[i]] <= w_in_data[i];
            end
        end
    end

    assign write_enable = write_enable_q;
    assign write_addr   = write_addr_q;
    assign write_data   = write_data_q;
    assign idle         = (cnt_q[0] == '0) && (cnt_q[1] == '0) && (cnt_q[2] == '0)
                          && !write_enable_q;

endmodule
`default_nettype wire
